// File: rtl/alu_operand_latch.sv
// alu_operand_latch: collects operand A, then operand B plus an op code,
// from a shared 8-bit databus. It then holds the complete operation stable
// for the ALU until the result latch grabs it. It also counts completed
// grabs and keeps a sticky flag for loads that were dropped while an
// operation was waiting to be grabbed.
module alu_operand_latch (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] bus_in,
    input  logic       load,
    input  logic [2:0] op_in,
    input  logic       abort,
    input  logic       grab,
    output logic [7:0] operand_a,
    output logic [7:0] operand_b,
    output logic [2:0] op_out,
    output logic       valid,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] op_count
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] WAIT_B = 2'b01;
    localparam logic [1:0] ISSUE  = 2'b10;

    logic [1:0] state;
    logic [1:0] next_state;
    logic       capture_a;
    logic       capture_b;
    logic       count_inc;
    logic       set_overrun;

    // Decide the next state and which registers update; abort outranks grab, which outranks load
    always_comb begin
        next_state  = state;
        capture_a   = 1'b0;
        capture_b   = 1'b0;
        count_inc   = 1'b0;
        set_overrun = 1'b0;
        case (state)
            IDLE: begin
                if (!abort && load) begin
                    capture_a  = 1'b1;
                    next_state = WAIT_B;
                end
            end
            WAIT_B: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (load) begin
                    capture_b  = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    next_state = IDLE;
                end else if (grab) begin
                    count_inc = 1'b1;
                    if (load) begin
                        capture_a  = 1'b1;
                        next_state = WAIT_B;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (load) begin
                    set_overrun = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register plus the registered valid/busy flags, which follow the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            valid <= (next_state == ISSUE);
            busy  <= (next_state != IDLE);
        end
    end

    // Operand and op-code registers; abort leaves the old values in place
    always_ff @(posedge clock) begin
        if (reset) begin
            operand_a <= 8'h00;
            operand_b <= 8'h00;
            op_out    <= 3'd0;
        end else begin
            if (capture_a) begin
                operand_a <= bus_in;
            end
            if (capture_b) begin
                operand_b <= bus_in;
                op_out    <= op_in;
            end
        end
    end

    // Grab counter (wraps silently) and sticky overrun flag
    always_ff @(posedge clock) begin
        if (reset) begin
            op_count <= 8'h00;
            overrun  <= 1'b0;
        end else begin
            if (count_inc) begin
                op_count <= op_count + 8'd1;
            end
            if (set_overrun) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/alu_operand_latch.md
ALU_OPERAND_LATCH -- requirements
Module: alu_operand_latch

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, as listed first below.
REQ-002 The port `clock` SHALL be an input, 1 bit wide; it is the single clock, and all state updates on its rising edge.
REQ-003 The port `reset` SHALL be an input, 1 bit wide; it is a synchronous, active-high reset.
REQ-004 The port `bus_in` SHALL be an input, 8 bits wide; it is the databus value to capture.
REQ-005 The port `load` SHALL be an input, 1 bit wide; when high, `bus_in` is valid for capture this cycle.
REQ-006 The port `op_in` SHALL be an input, 3 bits wide; it is the ALU operation code, sampled together with operand B.
REQ-007 The port `abort` SHALL be an input, 1 bit wide; it discards the partially loaded operation.
REQ-008 The port `grab` SHALL be an input, 1 bit wide; the ALU result latch is consuming the issued operation this cycle.
REQ-009 The port `operand_a` SHALL be an output, 8 bits wide; it is the registered first operand.
REQ-010 The port `operand_b` SHALL be an output, 8 bits wide; it is the registered second operand.
REQ-011 The port `op_out` SHALL be an output, 3 bits wide; it is the registered operation code.
REQ-012 The port `valid` SHALL be an output, 1 bit wide; it indicates operands and op are complete and stable for the ALU.
REQ-013 The port `busy` SHALL be an output, 1 bit wide; it indicates that an operation is in progress (state is not IDLE).
REQ-014 The port `overrun` SHALL be an output, 1 bit wide; it is a sticky flag meaning a `load` arrived while `valid` was high and was dropped.
REQ-015 The port `op_count` SHALL be an output, 8 bits wide; it counts completed grabs and wraps modulo 256.

Function
REQ-016 The state machine SHALL have three states: IDLE (wait A), WAIT_B, and ISSUE; the state register is 2 bits, and the fourth encoding SHALL return to IDLE on the next edge.
REQ-017 In IDLE with `load`=1, the block SHALL set `operand_a` to `bus_in` and go to WAIT_B; with `load`=0 it SHALL hold.
REQ-018 In WAIT_B with `load`=1, the block SHALL set `operand_b` to `bus_in` and `op_out` to `op_in`, then go to ISSUE; with `load`=0 it SHALL hold with no timeout.
REQ-019 The `valid` output SHALL be a registered output equal to 1 exactly while in ISSUE, asserting on the first cycle after the B capture edge (latency of one clock from the second `load`).
REQ-020 In ISSUE, `operand_a`, `operand_b` and `op_out` SHALL remain stable until `grab`=1 is sampled.
REQ-021 In ISSUE with `grab`=1 and `load`=0, the block SHALL go to IDLE and increment `op_count`.
REQ-022 In ISSUE with `grab`=1 and `load`=1 in the same cycle, the block SHALL increment `op_count`, capture `bus_in` into `operand_a`, and go to WAIT_B (back-to-back issue; `overrun` is unchanged).
REQ-023 In ISSUE with `load`=1 and `grab`=0, the block SHALL drop the data, set `overrun`=1, and remain in ISSUE.
REQ-024 The `overrun` flag SHALL clear only on `reset`.
REQ-025 A `grab` sampled outside ISSUE SHALL be ignored: no state change and no count change.
REQ-026 An `abort` in WAIT_B or ISSUE SHALL send the block to IDLE and SHALL NOT increment `op_count`, even if `grab`=1 in the same cycle.
REQ-027 An `abort` in IDLE SHALL have no effect, and `abort` SHALL take priority over `load` in every state.
REQ-028 Operand registers SHALL NOT be cleared by `abort`; the old values are retained, but `valid`=0.
REQ-029 `op_count` SHALL wrap from 255 to 0 with no flag.
REQ-030 Event priority SHALL be: `reset` > `abort` > `grab` > `load`.

Reset
REQ-031 When `reset`=1 at a rising edge, the block SHALL enter IDLE and set `operand_a`=0x00, `operand_b`=0x00, `op_out`=0, `valid`=0, `busy`=0, `overrun`=0 and `op_count`=0x00.
REQ-032 A `reset` asserted mid-operation (in WAIT_B or ISSUE) SHALL discard all progress on that edge, and `load`/`grab` on the same edge SHALL be ignored.
REQ-033 Outputs SHALL be undefined only before the first reset edge; no asynchronous path to the outputs SHALL exist.

Verification
REQ-034 The bench SHALL cover a basic sequence: reset; `load` with 0x3C; `load` with 0xA5 and `op_in`=3 -> the next cycle shows `valid`=1, `operand_a`=0x3C, `operand_b`=0xA5, `op_out`=3; `grab` -> `valid`=0, `op_count`=1, state IDLE.
REQ-035 The bench SHALL cover overrun: in ISSUE, `load` with 0x77 and `grab`=0 -> operands unchanged, `overrun`=1, and it stays 1 after a later `grab`; then `reset` -> `overrun`=0.
REQ-036 The bench SHALL cover back-to-back issue: in ISSUE, `grab`=1 and `load`=1 with 0x11 in the same cycle -> `op_count` increments, `operand_a`=0x11, `busy`=1, `valid`=0; the next `load` of 0x22 -> `valid`=1.
REQ-037 The bench SHALL cover abort: after loading A=0x05, `abort`=1 with `load`=1 on 0x09 -> state IDLE, `operand_a` stays 0x05, `busy`=0; separately, in ISSUE, `abort`=1 with `grab`=1 -> `op_count` unchanged.
REQ-038 The bench SHALL cover wrap: 256 complete load/load/grab operations -> `op_count` reads 0x00, and `grab` pulses while in IDLE leave it unchanged.
REQ-039 The bench SHALL cover reset mid-operation: `reset` asserted in WAIT_B together with `load`=1 -> all outputs at their reset values on the next cycle, and the following `load` captures into `operand_a`.
